// File: rtl/axis_byte_repack.sv
// Byte-granular AXI-Stream width converter (IN_BYTES -> OUT_BYTES) with tlast flush.
// Define AXIS_BYTE_REPACK_STATS_EN to add beat/packet statistics counters.
module axis_byte_repack #(
  parameter int IN_BYTES   = 4,
  parameter int OUT_BYTES  = 5,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [IN_BYTES*BYTE_WIDTH-1:0]   s_tdata,
  input  logic                             s_tvalid,
  output logic                             s_tready,
  input  logic                             s_tlast,
  output logic [OUT_BYTES*BYTE_WIDTH-1:0]  m_tdata,
  output logic [OUT_BYTES-1:0]             m_tkeep,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic                             m_tlast
`ifdef AXIS_BYTE_REPACK_STATS_EN
  ,
  output logic [31:0]                      stat_in_beats,
  output logic [31:0]                      stat_out_beats,
  output logic [31:0]                      stat_pkts
`endif
);
  localparam int BUF_BYTES = IN_BYTES + OUT_BYTES;
  localparam int CW        = $clog2(BUF_BYTES + 1);
  localparam logic [CW-1:0] OUT_C = CW'(OUT_BYTES);
  localparam logic [CW-1:0] IN_C  = CW'(IN_BYTES);

  logic [BYTE_WIDTH-1:0] r_buf [BUF_BYTES];
  logic [CW-1:0]         r_cnt;
  logic                  r_last_pend;
  logic                  r_run;

  logic                  w_full, w_push, w_pop;
  logic [CW-1:0]         w_pop_n, w_cnt_pop, w_cnt_nxt;
  logic [BYTE_WIDTH-1:0] w_buf_nxt [BUF_BYTES];

  // Handshake decode uses registered state only; r_run holds s_tready low through reset.
  assign w_full    = r_cnt >= OUT_C;
  assign s_tready  = r_run && !r_last_pend && (r_cnt <= OUT_C);
  assign m_tvalid  = w_full || (r_last_pend && (r_cnt != '0));
  assign m_tlast   = r_last_pend && (r_cnt <= OUT_C);
  assign w_push    = s_tvalid && s_tready;
  assign w_pop     = m_tvalid && m_tready;
  assign w_pop_n   = !w_pop ? '0 : (w_full ? OUT_C : r_cnt);
  assign w_cnt_pop = r_cnt - w_pop_n;
  assign w_cnt_nxt = w_cnt_pop + (w_push ? IN_C : '0);

  always_comb begin
    m_tdata = '0;
    m_tkeep = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      m_tdata[i*BYTE_WIDTH +: BYTE_WIDTH] = r_buf[i];
      m_tkeep[i] = CW'(i) < r_cnt;
    end
  end

  // Bytes at or above cnt are kept zero, so the shift zero-fills and the append
  // only has to overwrite the slots at the post-pop count.
  always_comb begin
    for (int i = 0; i < BUF_BYTES; i++) w_buf_nxt[i] = '0;
    for (int k = 0; k <= OUT_BYTES; k++) begin
      if (w_pop_n == CW'(k)) begin
        for (int i = 0; i < BUF_BYTES - k; i++) w_buf_nxt[i] = r_buf[i+k];
      end
    end
    if (w_push) begin
      for (int i = 0; i < BUF_BYTES; i++) begin
        for (int j = 0; j < IN_BYTES; j++) begin
          if (i == int'(w_cnt_pop) + j) w_buf_nxt[i] = s_tdata[j*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf       <= '{default: '0};
      r_cnt       <= '0;
      r_last_pend <= 1'b0;
      r_run       <= 1'b0;
    end else begin
      r_buf <= w_buf_nxt;
      r_cnt <= w_cnt_nxt;
      r_run <= 1'b1;
      if (w_pop && m_tlast)
        r_last_pend <= 1'b0;
      else if (w_push && s_tlast)
        r_last_pend <= 1'b1;
    end
  end

`ifdef AXIS_BYTE_REPACK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_in_beats  <= '0;
      stat_out_beats <= '0;
      stat_pkts      <= '0;
    end else begin
      if (w_push)            stat_in_beats  <= stat_in_beats + 32'd1;
      if (w_pop)             stat_out_beats <= stat_out_beats + 32'd1;
      if (w_pop && m_tlast)  stat_pkts      <= stat_pkts + 32'd1;
    end
  end
`endif

endmodule
